// File: rtl/scarv_cop_cprs_wb.sv
// Writeback sequencer for the COP register file write port. It converts
// byte/half/word results to lane enables and splits 64-bit results into a pair of word writes.
module scarv_cop_cprs_wb #(
    parameter bit PAIR_EN = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    output logic        g_clk_req,
    input  logic        cprs_init,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [3:0]  wb_addr,
    input  logic        wb_wide,
    input  logic [1:0]  wb_size,
    input  logic [1:0]  wb_lane,
    input  logic [63:0] wb_wdata,
    output logic        wb_done,
    output logic        wb_err,
    output logic [3:0]  crd_wen,
    output logic [3:0]  crd_addr,
    output logic [31:0] crd_wdata
);

    // Handshake: a request transfers on any edge where wb_valid & wb_ready;
    // wb_ready never depends on wb_valid.
    typedef enum logic {IDLE = 1'b0, HI = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [2:0]  hi_addr_q, hi_addr_d;
    logic [31:0] hi_data_q, hi_data_d;
    logic [3:0]  wen_d, addr_d;
    logic [31:0] wdata_d;
    logic        done_d, err_d;
    logic        accept;

    assign wb_ready  = g_resetn & (state_q == IDLE) & ~cprs_init;
    assign accept    = wb_valid & wb_ready;
    assign g_clk_req = wb_valid | (state_q != IDLE) | (|crd_wen);

    always_comb begin
        state_d   = IDLE;
        hi_addr_d = hi_addr_q;
        hi_data_d = hi_data_q;
        wen_d     = 4'b0000;
        addr_d    = crd_addr;
        wdata_d   = crd_wdata;
        done_d    = 1'b0;
        err_d     = 1'b0;
        // cprs_init wins over everything: the register file is being zeroed.
        if (!cprs_init) begin
            if (state_q == HI) begin
                wen_d   = 4'b1111;
                addr_d  = {hi_addr_q, 1'b1};
                wdata_d = hi_data_q;
                done_d  = 1'b1;
            end else if (accept) begin
                if (wb_wide && PAIR_EN) begin
                    state_d   = HI;
                    hi_addr_d = wb_addr[3:1];
                    hi_data_d = wb_wdata[63:32];
                    wen_d     = 4'b1111;
                    addr_d    = {wb_addr[3:1], 1'b0};
                    wdata_d   = wb_wdata[31:0];
                end else if (wb_wide) begin
                    wen_d   = 4'b1111;
                    addr_d  = wb_addr;
                    wdata_d = wb_wdata[31:0];
                    done_d  = 1'b1;
                end else begin
                    addr_d = wb_addr;
                    unique case (wb_size)
                        2'b00: begin
                            wen_d   = 4'b0001 << wb_lane;
                            wdata_d = {4{wb_wdata[7:0]}};
                            done_d  = 1'b1;
                        end
                        2'b01: begin
                            wen_d   = wb_lane[1] ? 4'b1100 : 4'b0011;
                            wdata_d = {2{wb_wdata[15:0]}};
                            done_d  = 1'b1;
                        end
                        2'b10: begin
                            wen_d   = 4'b1111;
                            wdata_d = wb_wdata[31:0];
                            done_d  = 1'b1;
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q   <= IDLE;
            hi_addr_q <= 3'd0;
            hi_data_q <= 32'd0;
            crd_wen   <= 4'b0000;
            crd_addr  <= 4'd0;
            crd_wdata <= 32'd0;
            wb_done   <= 1'b0;
            wb_err    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_addr_q <= hi_addr_d;
            hi_data_q <= hi_data_d;
            crd_wen   <= wen_d;
            crd_addr  <= addr_d;
            crd_wdata <= wdata_d;
            wb_done   <= done_d;
            wb_err    <= err_d;
        end
    end

endmodule

// File: tb/tb_scarv_cop_cprs_wb.sv
// Directed bench for scarv_cop_cprs_wb: per-cycle expected write records are
// queued when a request is driven and compared on the following cycle.
module tb_scarv_cop_cprs_wb;

    typedef struct packed {
        logic [3:0]  wen;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        done;
        logic        err;
        logic        full;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        cprs_init;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic        wb_wide;
    logic [1:0]  wb_size;
    logic [1:0]  wb_lane;
    logic [63:0] wb_wdata;

    logic        g_clk_req, wb_ready, wb_done, wb_err;
    logic [3:0]  crd_wen, crd_addr;
    logic [31:0] crd_wdata;
    logic        b_clk_req, b_ready, b_done, b_err;
    logic [3:0]  b_wen, b_addr;
    logic [31:0] b_wdata;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // clock / reset block
    always #5 g_clk = ~g_clk;

    scarv_cop_cprs_wb #(.PAIR_EN(1'b1)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(g_clk_req),
        .cprs_init(cprs_init), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_wide(wb_wide), .wb_size(wb_size),
        .wb_lane(wb_lane), .wb_wdata(wb_wdata), .wb_done(wb_done),
        .wb_err(wb_err), .crd_wen(crd_wen), .crd_addr(crd_addr),
        .crd_wdata(crd_wdata)
    );

    scarv_cop_cprs_wb #(.PAIR_EN(1'b0)) dut_np (
        .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(b_clk_req),
        .cprs_init(cprs_init), .wb_valid(wb_valid), .wb_ready(b_ready),
        .wb_addr(wb_addr), .wb_wide(wb_wide), .wb_size(wb_size),
        .wb_lane(wb_lane), .wb_wdata(wb_wdata), .wb_done(b_done),
        .wb_err(b_err), .crd_wen(b_wen), .crd_addr(b_addr),
        .crd_wdata(b_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and compare DUT outputs against the oldest expectation.
    task automatic tick();
        exp_t e;
        @(posedge g_clk);
        #1;
        e = exp_q.pop_front();
        chk("crd_wen", {60'd0, crd_wen}, {60'd0, e.wen});
        chk("wb_done", {63'd0, wb_done}, {63'd0, e.done});
        chk("wb_err",  {63'd0, wb_err},  {63'd0, e.err});
        if (e.full || e.wen != 4'b0000) begin
            chk("crd_addr",  {60'd0, crd_addr},  {60'd0, e.addr});
            chk("crd_wdata", {32'd0, crd_wdata}, {32'd0, e.wdata});
        end
    endtask

    // Driver: apply one cycle of request inputs, check wb_ready, queue the expected write.
    task automatic issue(input logic v, input logic [3:0] a, input logic w,
                         input logic [1:0] sz, input logic [1:0] ln, input logic [63:0] d,
                         input logic exp_rdy, input logic [3:0] e_wen, input logic [3:0] e_addr,
                         input logic [31:0] e_wdata, input logic e_done, input logic e_err,
                         input logic e_full);
        exp_t e;
        wb_valid = v; wb_addr = a; wb_wide = w; wb_size = sz; wb_lane = ln; wb_wdata = d;
        #1;
        chk("wb_ready", {63'd0, wb_ready}, {63'd0, exp_rdy});
        e = '{wen: e_wen, addr: e_addr, wdata: e_wdata, done: e_done, err: e_err, full: e_full};
        exp_q.push_back(e);
        tick();
    endtask

    task automatic idle();
        issue(1'b0, 4'd0, 1'b0, 2'b10, 2'd0, 64'd0, 1'b1, 4'b0000, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] d;
        logic [1:0]  ln;

        g_resetn = 1'b0; cprs_init = 1'b0; wb_valid = 1'b1; wb_addr = 4'hF;
        wb_wide = 1'b0; wb_size = 2'b10; wb_lane = 2'd0; wb_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (2) begin
            @(posedge g_clk);
            #1;
            chk("rst_ready", {63'd0, wb_ready}, 64'd0);
            chk("rst_wen",   {60'd0, crd_wen}, 64'd0);
            chk("rst_addr",  {60'd0, crd_addr}, 64'd0);
            chk("rst_wdata", {32'd0, crd_wdata}, 64'd0);
            chk("rst_done",  {63'd0, wb_done}, 64'd0);
            chk("rst_err",   {63'd0, wb_err}, 64'd0);
        end
        g_resetn = 1'b1;

        // byte / half / word
        issue(1, 4'd5, 0, 2'b00, 2'd2, 64'hAB, 1, 4'b0100, 4'd5, 32'hABAB_ABAB, 1, 0, 0);
        issue(1, 4'd3, 0, 2'b01, 2'd3, 64'h1234, 1, 4'b1100, 4'd3, 32'h1234_1234, 1, 0, 0);
        issue(1, 4'd8, 0, 2'b01, 2'd0, 64'h5555_BEEF, 1, 4'b0011, 4'd8, 32'hBEEF_BEEF, 1, 0, 0);
        issue(1, 4'd9, 0, 2'b10, 2'd1, 64'h1_DEAD_BEEF, 1, 4'b1111, 4'd9, 32'hDEAD_BEEF, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            d  = {$urandom, $urandom};
            ln = 2'($urandom_range(0, 3));
            issue(1, 4'd14, 0, 2'b00, ln, d, 1, 4'b0001 << ln, 4'd14, {4{d[7:0]}}, 1, 0, 0);
        end

        // back-to-back words
        for (int i = 1; i <= 4; i++) begin
            d = {$urandom, $urandom};
            issue(1, 4'(i), 0, 2'b10, 2'd0, d, 1, 4'b1111, 4'(i), d[31:0], 1, 0, 0);
        end
        idle();

        // wide pair; the non-paired instance writes the low word to wb_addr once
        issue(1, 4'd7, 1, 2'b11, 2'd0, 64'h1111_2222_3333_4444, 1, 4'b1111, 4'd6, 32'h3333_4444, 0, 0, 0);
        chk("np_wen",     {60'd0, b_wen}, 64'hF);
        chk("np_addr",    {60'd0, b_addr}, 64'd7);
        chk("np_wdata",   {32'd0, b_wdata}, 64'h3333_4444);
        chk("np_done",    {63'd0, b_done}, 64'd1);
        chk("np_err",     {63'd0, b_err}, 64'd0);
        chk("np_ready",   {63'd0, b_ready}, 64'd1);
        chk("np_clk_req", {63'd0, b_clk_req}, 64'd1);
        chk("hi_clk_req", {63'd0, g_clk_req}, 64'd1);
        issue(0, 4'd0, 0, 2'b10, 2'd0, 64'd0, 0, 4'b1111, 4'd7, 32'h1111_2222, 1, 0, 0);
        chk("np_idle_wen", {60'd0, b_wen}, 64'd0);
        d = {$urandom, $urandom};
        issue(1, 4'd12, 1, 2'b00, 2'd0, d, 1, 4'b1111, 4'd12, d[31:0], 0, 0, 0);
        issue(0, 4'd0, 0, 2'b10, 2'd0, 64'd0, 0, 4'b1111, 4'd13, d[63:32], 1, 0, 0);

        // illegal size
        issue(1, 4'd2, 0, 2'b11, 2'd0, 64'hCAFE, 1, 4'b0000, 4'd0, 32'd0, 0, 1, 0);
        idle();

        // cprs_init aborts a pending high write, and blocks accepts while high
        d = {$urandom, $urandom};
        issue(1, 4'hB, 1, 2'b10, 2'd0, d, 1, 4'b1111, 4'hA, d[31:0], 0, 0, 0);
        cprs_init = 1'b1;
        issue(0, 4'd0, 0, 2'b10, 2'd0, 64'd0, 0, 4'b0000, 4'd0, 32'd0, 0, 0, 0);
        issue(1, 4'd8, 0, 2'b10, 2'd0, 64'h77, 0, 4'b0000, 4'd0, 32'd0, 0, 0, 0);
        cprs_init = 1'b0;
        issue(1, 4'd3, 0, 2'b10, 2'd0, 64'h0BAD_F00D, 1, 4'b1111, 4'd3, 32'h0BAD_F00D, 1, 0, 0);

        // reset in the middle of a wide request
        d = {$urandom, $urandom};
        issue(1, 4'd5, 1, 2'b10, 2'd0, d, 1, 4'b1111, 4'd4, d[31:0], 0, 0, 0);
        g_resetn = 1'b0;
        issue(0, 4'd0, 0, 2'b10, 2'd0, 64'd0, 0, 4'b0000, 4'd0, 32'd0, 0, 0, 1);
        g_resetn = 1'b1;
        issue(1, 4'd15, 0, 2'b10, 2'd0, 64'h1357_9BDF, 1, 4'b1111, 4'd15, 32'h1357_9BDF, 1, 0, 0);
        idle();

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scarv_cop_cprs_wb.md
Name: scarv_cop_cprs_wb

Overview:
Writeback sequencer that drives the single write port (crd_wen/crd_addr/crd_wdata) of the COP general purpose register file. It accepts result requests from COP functional units over a valid/ready handshake. Byte and halfword results are converted into byte-lane enables with replicated data. 64-bit results are split into two sequential word writes to an even/odd register pair. Output is registered, so the register file sees a clean, single-driver write stream.

Parameters:
PAIR_EN, 1, when 0 wide requests are treated as plain word writes of wb_wdata[31:0] to wb_addr (no second cycle).

Ports:
g_clk  input  1  global clock
g_resetn  input  1  synchronous active-low reset
g_clk_req  output  1  clock request; = wb_valid | (state!=IDLE) | (|crd_wen)
cprs_init  input  1  xc.init executing; aborts and flushes
wb_valid  input  1  request valid
wb_ready  output  1  request accepted when wb_valid & wb_ready
wb_addr  input  4  destination register
wb_wide  input  1  64-bit pair write
wb_size  input  2  00 byte, 01 half, 10 word, 11 illegal (ignored when wb_wide)
wb_lane  input  2  byte position for byte/half writes
wb_wdata  input  64  result; narrow uses [31:0], wide low word [31:0], high word [63:32]
wb_done  output  1  pulse: request fully committed
wb_err  output  1  pulse: illegal size request retired without write
crd_wen  output  4  register file byte write enables
crd_addr  output  4  register file write address
crd_wdata  output  32  register file write data

Behaviour:
- Reset (g_resetn low at posedge): state=IDLE; crd_wen=0, crd_addr=0, crd_wdata=0, wb_done=0, wb_err=0. wb_ready=0 while g_resetn low.
- wb_ready = g_resetn & (state==IDLE) & !cprs_init (combinational).
- States: IDLE, HI. An accept in IDLE with wb_wide & PAIR_EN -> HI; HI -> IDLE unconditionally next cycle.
- Latency: request accepted at edge T appears on crd_* during cycle T+1 and is captured by the register file at the end of T+1.
- Narrow throughput: 1 request/cycle. Back-to-back accepts produce consecutive write cycles.
- Byte (size 00): crd_wen=1<<wb_lane; crd_wdata={4{wb_wdata[7:0]}}.
- Half (size 01): wb_lane[0] ignored; crd_wen = wb_lane[1] ? 4'b1100 : 4'b0011; crd_wdata={2{wb_wdata[15:0]}}.
- Word (size 10): crd_wen=4'b1111; crd_wdata=wb_wdata[31:0].
- Illegal (size 11, not wide): request accepted; crd_wen=0 in T+1; wb_err=1 in T+1.
- Wide: low half goes in T+1 to crd_addr={wb_addr[3:1],1'b0}, wen=1111, data=[31:0]. High half goes in T+2 to {wb_addr[3:1],1'b1}, wen=1111, data=[63:32] (held internally). wb_addr[0] ignored. wb_ready=0 during T+1 (state HI).
- wb_done: high in the cycle carrying the final write (T+1 narrow/illegal, T+2 wide). Never high together with wb_err.
- Idle cycles: crd_wen=0. crd_addr/crd_wdata hold last value (don't-care when wen=0).
- cprs_init high at edge: no accept that edge; the next cycle has crd_wen=0, wb_done=0, wb_err=0 and state=IDLE. A pending HI write is dropped, since the register file is being zeroed. A write already on crd_* in the same cycle as cprs_init is overridden by the register file's init priority.
- Reset mid-wide: HI write dropped, all outputs to reset values.
- No internal buffering beyond the output register and the 32-bit high-word holder.

Test Plan:
- Reset: hold g_resetn low 2 cycles with wb_valid=1 -> wb_ready=0, crd_wen=0, crd_addr=0, crd_wdata=0, wb_done=0.
- Byte/half/word: accept byte addr=5 lane=2 data=0xAB -> next cycle crd_wen=0100, crd_addr=5, crd_wdata=0xABABABAB, wb_done=1. Half lane=3 data=0x1234 -> wen=1100, wdata=0x12341234. Word -> wen=1111.
- Back-to-back: 4 consecutive word requests to addr 1..4 -> wb_ready stays 1; four consecutive write cycles, addr 1,2,3,4, wb_done high each cycle.
- Wide: addr=7, data=0x11112222_33334444 -> T+1 addr=6 wdata=0x33334444; T+2 addr=7 wdata=0x11112222; wb_ready=0 in T+1; wb_done only in T+2. Repeat with PAIR_EN=0 -> single write addr=7 wdata=0x33334444.
- Illegal: size=11 -> accepted, crd_wen=0, wb_err=1 one cycle, wb_done=0.
- Abort: accept a wide request, assert cprs_init in T+1 -> T+2 crd_wen=0, state IDLE, wb_ready=1 in T+2 once cprs_init drops. Repeat with g_resetn low in T+1 -> same with reset values.
